// File: rtl/text_entry_ctrl_if.sv
// text_entry_ctrl_if: button/switch inputs and text-buffer write/cursor outputs of text_entry_ctrl.
// master = text_entry_ctrl, slave = board/character-store side.
interface text_entry_ctrl_if #(parameter int ADDR_W = 10);
   logic [2:0]        buttons;
   logic [6:0]        switches;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [6:0]        wr_data;
   logic [5:0]        cursor_col;
   logic [4:0]        cursor_row;
   logic              cursor_vis;
   logic              busy;
   modport master (input buttons, switches,
                   output wr_en, wr_addr, wr_data, cursor_col, cursor_row, cursor_vis, busy);
   modport slave  (output buttons, switches,
                   input wr_en, wr_addr, wr_data, cursor_col, cursor_row, cursor_vis, busy);
endinterface

// File: rtl/text_entry_ctrl.sv
// text_entry_ctrl: debounced buttons drive a text cursor and 7-bit writes into the text buffer.
// Optional CURSOR_BLINK_EN macro builds the cursor blink counter; otherwise cursor_vis is tied high.
module text_entry_ctrl #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int COLS            = 60,
   parameter int ROWS            = 17,
   parameter int ADDR_W          = 10,
   parameter int BLINK_CYCLES    = 12500000
) (
   input  logic clk,
   input  logic reset,
   text_entry_ctrl_if.master bus
);
   localparam int N  = COLS * ROWS;
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int AW1 = ADDR_W + 1;
   typedef enum logic [1:0] {CLEAR, IDLE, ACT} state_t;
   state_t            r_state;
   logic [2:0]        r_sync1, r_sync2, r_lvl, r_lvl_d, r_act;
   logic [CW-1:0]     r_cnt [3];
   logic [ADDR_W:0]   r_clr;
   logic              r_wr_en, r_busy;
   logic [ADDR_W-1:0] r_wr_addr;
   logic [6:0]        r_wr_data;
   logic [5:0]        r_col;
   logic [4:0]        r_row;
   logic [2:0]        w_press;
   logic              w_last_col, w_last_row;
   logic [5:0]        w_bk_col, w_nx_col;
   logic [4:0]        w_bk_row, w_nx_row, w_row_inc;
   logic [ADDR_W-1:0] w_addr, w_bk_addr;

   // levels are kept in raw polarity: 1 = released
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         r_sync1 <= '1;
         r_sync2 <= '1;
         r_lvl   <= '1;
         r_lvl_d <= '1;
         for (int i = 0; i < 3; i++) r_cnt[i] <= '0;
      end else begin
         r_sync1 <= bus.buttons;
         r_sync2 <= r_sync1;
         r_lvl_d <= r_lvl;
         for (int i = 0; i < 3; i++)
            if (r_sync2[i] == r_lvl[i]) r_cnt[i] <= '0;
            else if (r_cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
               r_cnt[i] <= '0;
               r_lvl[i] <= r_sync2[i];
            end else r_cnt[i] <= r_cnt[i] + 1'b1;
      end

   assign w_press    = r_lvl_d & ~r_lvl;
   assign w_last_col = r_col == 6'(COLS - 1);
   assign w_last_row = r_row == 5'(ROWS - 1);
   assign w_row_inc  = w_last_row ? '0 : r_row + 1'b1;
   assign w_bk_col   = r_col != 0 ? r_col - 1'b1 : r_row != 0 ? 6'(COLS - 1) : '0;
   assign w_bk_row   = (r_col == 0 && r_row != 0) ? r_row - 1'b1 : r_row;
   assign w_nx_col   = r_act[0] ? (w_last_col ? '0 : r_col + 1'b1) : r_act[1] ? w_bk_col : '0;
   assign w_nx_row   = r_act[0] ? (w_last_col ? w_row_inc : r_row) : r_act[1] ? w_bk_row : w_row_inc;
   assign w_addr     = ADDR_W'(r_row) * ADDR_W'(COLS) + ADDR_W'(r_col);
   assign w_bk_addr  = ADDR_W'(w_bk_row) * ADDR_W'(COLS) + ADDR_W'(w_bk_col);

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         r_state   <= CLEAR;
         r_clr     <= '0;
         r_act     <= '0;
         r_wr_en   <= 1'b0;
         r_wr_addr <= '0;
         r_wr_data <= '0;
         r_col     <= '0;
         r_row     <= '0;
         r_busy    <= 1'b1;
      end else
         case (r_state)
            CLEAR:
               if (r_clr == AW1'(N)) begin
                  r_wr_en <= 1'b0;
                  r_busy  <= 1'b0;
                  r_state <= IDLE;
               end else begin
                  r_wr_en   <= 1'b1;
                  r_wr_addr <= r_clr[ADDR_W-1:0];
                  r_wr_data <= 7'h20;
                  r_clr     <= r_clr + 1'b1;
               end
            IDLE:
               if (|w_press) begin
                  r_state   <= ACT;
                  r_act     <= w_press[0] ? 3'b001 : w_press[1] ? 3'b010 : 3'b100;
                  r_wr_en   <= w_press[0] | w_press[1];
                  r_wr_addr <= w_press[0] ? w_addr : w_bk_addr;
                  r_wr_data <= w_press[0] ? bus.switches : 7'h20;
               end
            ACT: begin
               r_wr_en <= 1'b0;
               r_col   <= w_nx_col;
               r_row   <= w_nx_row;
               r_state <= IDLE;
            end
            default: r_state <= CLEAR;
         endcase

`ifdef CURSOR_BLINK_EN
   localparam int BW = $clog2(BLINK_CYCLES + 1);
   logic [BW-1:0] r_blink;
   logic          r_vis;
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         r_blink <= '0;
         r_vis   <= 1'b1;
      end else if (r_state == ACT && (w_nx_col != r_col || w_nx_row != r_row)) begin
         r_blink <= '0;
         r_vis   <= 1'b1;
      end else if (r_blink == BW'(BLINK_CYCLES - 1)) begin
         r_blink <= '0;
         r_vis   <= ~r_vis;
      end else r_blink <= r_blink + 1'b1;
   assign bus.cursor_vis = r_vis;
`else
   assign bus.cursor_vis = 1'b1;
`endif

   assign bus.wr_en      = r_wr_en;
   assign bus.wr_addr    = r_wr_addr;
   assign bus.wr_data    = r_wr_data;
   assign bus.cursor_col = r_col;
   assign bus.cursor_row = r_row;
   assign bus.busy       = r_busy;
endmodule

// File: tb/tb_text_entry_ctrl.sv
// tb_text_entry_ctrl: directed plus random button sequences checked against a linear-position
// cursor model and a shadow text buffer.
module tb_text_entry_ctrl;
   localparam int DEB = 4, C = 4, R = 3, N = C * R, AW = 4, BL = 8;
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   text_entry_ctrl_if #(.ADDR_W(AW)) bus();
   text_entry_ctrl #(.DEBOUNCE_CYCLES(DEB), .COLS(C), .ROWS(R), .ADDR_W(AW), .BLINK_CYCLES(BL))
      dut (.clk(clk), .reset(reset), .bus(bus));

   int n_cmp = 0, n_err = 0;
   int wa[$], wd[$];
   int dut_mem [N];
   int ref_mem [N];
   int pos = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk)
      if (!reset && bus.wr_en === 1'b1) begin
         chk("addr_range", 32'(bus.wr_addr < AW'(N)), 1);
         wa.push_back(int'(bus.wr_addr));
         wd.push_back(int'(bus.wr_data));
         if (bus.wr_addr < AW'(N)) dut_mem[bus.wr_addr] = int'(bus.wr_data);
      end

   // releases reset at the current negedge and checks the full clear sweep
   task automatic sweep_chk();
      wa.delete();
      wd.delete();
      reset = 1'b0;
      for (int i = 1; i <= N + 1; i++) begin
         @(negedge clk);
         if (i == 1) chk("sweep_first_addr", bus.wr_addr, 0);
         if (i == N) begin
            chk("sweep_busy_hi", bus.busy, 1);
            chk("sweep_last_addr", bus.wr_addr, N - 1);
         end
      end
      chk("sweep_busy_lo", bus.busy, 0);
      chk("sweep_wr_en_lo", bus.wr_en, 0);
      chk("sweep_count", wa.size(), N);
      for (int i = 0; i < wa.size() && i < N; i++) begin
         chk("sweep_addr", wa[i], i);
         chk("sweep_data", wd[i], 'h20);
      end
      chk("sweep_col", bus.cursor_col, 0);
      chk("sweep_row", bus.cursor_row, 0);
      pos = 0;
      for (int i = 0; i < N; i++) ref_mem[i] = 'h20;
   endtask

   task automatic act(input logic [2:0] bits, input int hold, input logic [6:0] sw);
      int en, ea, ed;
      en = 0; ea = 0; ed = 0;
      wa.delete();
      wd.delete();
      bus.switches = sw;
      bus.buttons  = ~bits;
      repeat (hold) @(negedge clk);
      bus.buttons = 3'b111;
      repeat (DEB + 8) @(negedge clk);
      if (hold >= DEB && bits != 0) begin
         if (bits[0]) begin
            en = 1; ea = pos; ed = int'(sw); pos = (pos + 1) % N;
         end else if (bits[1]) begin
            pos = pos > 0 ? pos - 1 : 0; en = 1; ea = pos; ed = 'h20;
         end else pos = ((pos / C + 1) % R) * C;
      end
      if (en == 1) ref_mem[ea] = ed;
      chk("n_writes", wa.size(), en);
      if (en == 1 && wa.size() == 1) begin
         chk("wr_addr", wa[0], ea);
         chk("wr_data", wd[0], ed);
      end
      chk("cursor_col", bus.cursor_col, pos % C);
      chk("cursor_row", bus.cursor_row, pos / C);
      chk("busy_idle", bus.busy, 0);
   endtask

   initial begin
      int t;
      logic v, all_one;
      bus.buttons  = 3'b111;
      bus.switches = 7'h00;
      repeat (3) @(negedge clk);
      chk("rst_wr_en", bus.wr_en, 0);
      chk("rst_wr_addr", bus.wr_addr, 0);
      chk("rst_wr_data", bus.wr_data, 0);
      chk("rst_col", bus.cursor_col, 0);
      chk("rst_row", bus.cursor_row, 0);
      chk("rst_vis", bus.cursor_vis, 1);
      chk("rst_busy", bus.busy, 1);
      sweep_chk();

      act(3'b001, 10, 7'h41);
      chk("first_type_col", bus.cursor_col, 1);
      for (int i = 0; i < N - 1; i++) act(3'b001, 10, 7'(7'h42 + i));
      chk("wrap_col", bus.cursor_col, 0);
      chk("wrap_row", bus.cursor_row, 0);
      act(3'b010, 10, 7'h00);
      act(3'b100, 10, 7'h00);
      act(3'b010, 10, 7'h00);
      chk("bk_row_col", bus.cursor_col, C - 1);
      act(3'b101, 10, 7'h5a);
      act(3'b010, 3, 7'h00);
      act(3'b010, DEB, 7'h00);

      for (int i = 0; i < 45; i++)
         act(($urandom_range(0, 4) == 0) ? 3'($urandom_range(1, 7)) : 3'(1 << $urandom_range(0, 2)),
             int'($urandom_range(1, 12)), 7'($urandom_range(0, 127)));

      for (int i = 0; i < N; i++) chk("mem", dut_mem[i], ref_mem[i]);

`ifdef CURSOR_BLINK_EN
      v = bus.cursor_vis; t = 0;
      while (bus.cursor_vis === v && t < 3 * BL) begin @(negedge clk); t++; end
      chk("blink_found", 32'(t < 3 * BL), 1);
      for (int k = 0; k < 2; k++) begin
         v = bus.cursor_vis; t = 0;
         while (bus.cursor_vis === v && t < 3 * BL) begin @(negedge clk); t++; end
         chk("blink_period", t, BL);
      end
`else
      all_one = 1'b1;
      repeat (3 * BL) begin @(negedge clk); all_one &= (bus.cursor_vis === 1'b1); end
      chk("vis_tied", all_one, 1);
`endif

      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      t = 0;
      while (!(bus.wr_en === 1'b1 && bus.wr_addr === AW'(5)) && t < 3 * N) begin @(negedge clk); t++; end
      chk("mid_sweep_found", 32'(t < 3 * N), 1);
      reset = 1'b1;
      #1;
      chk("mid_rst_wr_en", bus.wr_en, 0);
      chk("mid_rst_addr", bus.wr_addr, 0);
      chk("mid_rst_busy", bus.busy, 1);
      @(negedge clk);
      sweep_chk();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/text_entry_ctrl.md
# text_entry_ctrl

Text-entry front end for the character display. It debounces the three push buttons, tracks a text cursor, and issues one-cycle write requests of 7-bit character codes into the character store's text buffer. After every reset it first sweeps the whole buffer to spaces. It sits directly upstream of the character store, driven by the board's buttons and switches.

## Interface
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable cycles required to accept a button level change (10 ms at 50 MHz).
- `COLS`, default 60: text columns (480 px / 8).
- `ROWS`, default 17: text rows (272 px / 16).
- `ADDR_W`, default 10: buffer address width; must satisfy COLS*ROWS ≤ 2^ADDR_W.
- `BLINK_CYCLES`, default 12500000: cursor blink half-period.
- `clk` in 1: system clock, 50 MHz.
- `reset` in 1: reset, asynchronous, active-high.
- `buttons` in 3: raw push buttons, active-low; [0] = type, [1] = backspace, [2] = newline.
- `switches` in 7: character code to type.
- `wr_en` out 1: buffer write strobe, one cycle per write.
- `wr_addr` out ADDR_W: write address, row*COLS + col.
- `wr_data` out 7: character written.
- `cursor_col` out 6: current column.
- `cursor_row` out 5: current row.
- `cursor_vis` out 1: cursor visible this phase.
- `busy` out 1: clear sweep in progress.

## Operation
- Inputs `buttons` are passed through a 2-flop synchronizer. Each button has its own debounce counter: the counter resets on any mismatch between the synchronized input and the accepted level; when the count reaches DEBOUNCE_CYCLES the level is accepted. A press event is the accepted level going from released to pressed; there is no auto-repeat.
- FSM states are CLEAR, IDLE, and ACT.
  - CLEAR: write 7'h20 to addresses 0 .. COLS*ROWS-1, one per cycle, in ascending order, then go to IDLE. Press events during CLEAR are discarded.
  - IDLE: on a press event, latch the action and go to ACT.
  - ACT: issue the write, update the cursor, and return to IDLE.
- Type: write `switches` (sampled in ACT) at the cursor, then advance. At col COLS-1, wrap to col 0 of the next row; at the last cell, wrap to (0,0).
- Backspace: move back one cell (col 0 moves to col COLS-1 of the previous row), then write 7'h20 at the new position. At (0,0), stay in place and write 7'h20 at address 0.
- Newline: no write; set col 0 and row+1. The last row wraps to row 0.
- Simultaneous press events in the same cycle: priority is [0] > [1] > [2]. Lower-priority events are dropped.
- The address is computed from the cursor position at the time of the write; the address must never reach COLS*ROWS.

## Timing
- Reset values: `wr_en`=0, `wr_addr`=0, `wr_data`=0, cursor (0,0), `cursor_vis`=1, `busy`=1, state CLEAR, debounce levels released.
- First clear write occurs in the first clock after reset deasserts. `busy` falls in the cycle after the write to COLS*ROWS-1, so the sweep occupies exactly COLS*ROWS cycles of `wr_en`=1.
- Button to write latency: 2 synchronizer cycles + DEBOUNCE_CYCLES to acceptance, +1 cycle to IDLE→ACT, with `wr_en` high in the ACT cycle.
- Cursor outputs update in the cycle after ACT. Back-to-back accepted events are at least 2 cycles apart.
- Reset asserted mid-sweep or mid-ACT aborts the operation immediately and restarts the full clear sweep.
- A bounce shorter than DEBOUNCE_CYCLES produces no event.

## Configuration
- `CURSOR_BLINK_EN` defined: `cursor_vis` toggles every BLINK_CYCLES cycles. Any cursor movement forces `cursor_vis`=1 and restarts the blink counter.
- `CURSOR_BLINK_EN` undefined: `cursor_vis` is tied to 1 and no blink counter is built.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, COLS=4, ROWS=3.
- Reset release → `wr_en`=1 for exactly 12 cycles, `wr_addr` 0..11, `wr_data`=7'h20, then `busy`=0 and cursor (0,0).
- `switches`=7'h41, press [0] for 10 cycles → exactly one write of addr 0, data 7'h41; cursor becomes (1,0).
- Type 12 characters → last write at addr 11; cursor wraps to (0,0).
- Backspace at (0,0) → write 7'h20 at addr 0, cursor stays (0,0). Backspace at (0,1) → write 7'h20 at addr 3, cursor (3,0).
- Press [0] and [2] in the same cycle → only the type action occurs. A 3-cycle glitch on [1] → no write.
- Reset asserted while the sweep is at addr 5 → the sweep restarts at addr 0. With `CURSOR_BLINK_EN` and BLINK_CYCLES=8, `cursor_vis` toggles every 8 cycles while idle.
